// File: rtl/data_sram_bridge.sv
// data_sram_bridge: converts the MEM-stage single-cycle data SRAM request into
// an SRAM-like req/addr_ok/data_ok handshake. It stalls the pipeline while an
// access is in flight, holds the load word until the MEM stage advances, and
// drains responses that belong to a flushed instruction.
module data_sram_bridge #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              data_sram_en,
  input  logic [1:0]        data_sram_rlen,
  input  logic [3:0]        data_sram_wen,
  input  logic [ADDR_W-1:0] data_sram_addr,
  input  logic [DATA_W-1:0] data_sram_wdata,
  output logic [DATA_W-1:0] data_sram_rdata,
  output logic              mem_stall,
  input  logic              pipe_advance,
  input  logic              flush,
  output logic              data_req,
  output logic              data_wr,
  output logic [1:0]        data_size,
  output logic [ADDR_W-1:0] data_addr,
  output logic [3:0]        data_wstrb,
  output logic [DATA_W-1:0] data_wdata,
  input  logic              data_addr_ok,
  input  logic              data_data_ok,
  input  logic [DATA_W-1:0] data_rdata_i
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_ADDR = 2'd1,
    WAIT_DATA = 2'd2,
    DONE      = 2'd3
  } state_t;

  state_t            state_r;
  state_t            state_nxt_s;
  logic              cancel_r;
  logic              cancel_nxt_s;
  logic              wr_r;
  logic [1:0]        size_r;
  logic [ADDR_W-1:0] addr_r;
  logic [3:0]        wstrb_r;
  logic [DATA_W-1:0] wdata_r;
  logic [DATA_W-1:0] rdata_r;
  logic              issue_s;
  logic              capture_s;

  // Access size: loads use rlen, stores derive it from the strobe pattern.
  function automatic logic [1:0] req_size(input logic [3:0] wen, input logic [1:0] rlen);
    logic [1:0] size;
    case (wen)
      4'b0000:          size = rlen;
      4'b1111:          size = 2'd2;
      4'b0011, 4'b1100: size = 2'd1;
      default:          size = 2'd0;
    endcase
    return size;
  endfunction

  assign data_sram_rdata = rdata_r;

  // Next state, handshake outputs and stall; reset forces every output low.
  always_comb begin
    issue_s      = (state_r == IDLE) & data_sram_en & ~flush & ~rst;
    state_nxt_s  = state_r;
    cancel_nxt_s = cancel_r;
    capture_s    = 1'b0;
    mem_stall    = 1'b0;
    data_req     = 1'b0;
    data_wr      = 1'b0;
    data_size    = 2'd0;
    data_addr    = {ADDR_W{1'b0}};
    data_wstrb   = 4'b0000;
    data_wdata   = {DATA_W{1'b0}};
    case (state_r)
      IDLE: begin
        if (issue_s) begin
          data_req    = 1'b1;
          data_wr     = |data_sram_wen;
          data_size   = req_size(data_sram_wen, data_sram_rlen);
          data_addr   = data_sram_addr;
          data_wstrb  = data_sram_wen;
          data_wdata  = data_sram_wdata;
          mem_stall   = 1'b1;
          state_nxt_s = data_addr_ok ? WAIT_DATA : WAIT_ADDR;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      WAIT_ADDR: begin
        // A posted request is never retracted, even on flush.
        data_req   = 1'b1;
        data_wr    = wr_r;
        data_size  = size_r;
        data_addr  = addr_r;
        data_wstrb = wstrb_r;
        data_wdata = wdata_r;
        mem_stall  = 1'b1;
        if (flush) begin
          cancel_nxt_s = 1'b1;
        end else begin
          cancel_nxt_s = cancel_r;
        end
        if (data_addr_ok) begin
          state_nxt_s = WAIT_DATA;
        end else begin
          state_nxt_s = WAIT_ADDR;
        end
      end
      WAIT_DATA: begin
        mem_stall = 1'b1;
        if (data_data_ok) begin
          if (cancel_r | flush) begin
            cancel_nxt_s = 1'b0;
            state_nxt_s  = IDLE;
          end else begin
            capture_s   = ~wr_r;
            state_nxt_s = DONE;
          end
        end else if (flush) begin
          cancel_nxt_s = 1'b1;
        end else begin
          state_nxt_s = WAIT_DATA;
        end
      end
      DONE: begin
        if (pipe_advance | flush) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = DONE;
        end
      end
      default: begin
        state_nxt_s  = IDLE;
        cancel_nxt_s = 1'b0;
      end
    endcase
  end

  // State and cancel flag registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= IDLE;
      cancel_r <= 1'b0;
    end else begin
      state_r  <= state_nxt_s;
      cancel_r <= cancel_nxt_s;
    end
  end

  // Request registers hold the issued fields while addr_ok is pending.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_r    <= 1'b0;
      size_r  <= 2'd0;
      addr_r  <= {ADDR_W{1'b0}};
      wstrb_r <= 4'b0000;
      wdata_r <= {DATA_W{1'b0}};
    end else if (issue_s) begin
      wr_r    <= |data_sram_wen;
      size_r  <= req_size(data_sram_wen, data_sram_rlen);
      addr_r  <= data_sram_addr;
      wstrb_r <= data_sram_wen;
      wdata_r <= data_sram_wdata;
    end
  end

  // Load word captured on a live response and held until overwritten.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_r <= {DATA_W{1'b0}};
    end else if (capture_s) begin
      rdata_r <= data_rdata_i;
    end
  end

endmodule

// File: tb/tb_data_sram_bridge.sv
// Testbench for data_sram_bridge: directed scenarios with literal expectations
// followed by randomized traffic, all checked every cycle against a
// transaction-level model of the bridge and an SRAM-like slave.
module tb_data_sram_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        data_sram_en;
  logic [1:0]  data_sram_rlen;
  logic [3:0]  data_sram_wen;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic [31:0] data_sram_rdata;
  logic        mem_stall;
  logic        pipe_advance;
  logic        flush;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [3:0]  data_wstrb;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata_i;

  always #5 clk = ~clk;

  data_sram_bridge #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .data_sram_en(data_sram_en), .data_sram_rlen(data_sram_rlen),
    .data_sram_wen(data_sram_wen), .data_sram_addr(data_sram_addr),
    .data_sram_wdata(data_sram_wdata), .data_sram_rdata(data_sram_rdata),
    .mem_stall(mem_stall), .pipe_advance(pipe_advance), .flush(flush),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wstrb(data_wstrb), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
    .data_rdata_i(data_rdata_i)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int req_pulses = 0;

  // stimulus knobs
  logic        d_en, d_flush, d_adv, stray_ok;
  logic [1:0]  d_rlen;
  logic [3:0]  d_wen;
  logic [31:0] d_addr, d_wdata, rsp_data;
  int          alat, dlat;

  // slave
  logic        sl_pend;
  int          sl_cnt, sl_age;
  logic [31:0] sl_data;

  // transaction-level model
  logic        m_busy, m_acc, m_kill, m_done, m_wr;
  logic [1:0]  m_size;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic [3:0]  m_wstrb;

  // outputs sampled on the falling edge
  logic        obs_req, obs_wr, obs_stall;
  logic [1:0]  obs_size;
  logic [3:0]  obs_wstrb;
  logic [31:0] obs_addr, obs_rdata;

  logic [3:0] wen_tab [8] = '{4'b1111, 4'b0011, 4'b1100, 4'b0001,
                              4'b0010, 4'b0100, 4'b1000, 4'b1111};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [1:0] size_of(input logic [3:0] wen, input logic [1:0] rlen);
    int n;
    n = $countones(wen);
    if (n == 0) return rlen;
    if (n == 4) return 2'd2;
    if (n == 2) return 2'd1;
    return 2'd0;
  endfunction

  task automatic model_reset();
    m_busy = 1'b0; m_acc = 1'b0; m_kill = 1'b0; m_done = 1'b0; m_wr = 1'b0;
    m_size = 2'd0; m_addr = 32'd0; m_wdata = 32'd0; m_wstrb = 4'd0; m_rdata = 32'd0;
    sl_pend = 1'b0; sl_cnt = 0; sl_age = 0; sl_data = 32'd0;
  endtask

  // One clock cycle: drive, check at negedge, answer addr_ok, advance model.
  task automatic step();
    logic        iss, e_req, e_wr, e_stall;
    logic [1:0]  e_size;
    logic [3:0]  e_wstrb;
    logic [31:0] e_addr, e_wdata;
    data_sram_en = d_en; data_sram_rlen = d_rlen; data_sram_wen = d_wen;
    data_sram_addr = d_addr; data_sram_wdata = d_wdata;
    flush = d_flush; pipe_advance = d_adv;
    data_data_ok = 1'b0;
    data_rdata_i = $urandom;
    if (sl_pend) begin
      if (sl_cnt == 0) begin
        data_data_ok = 1'b1;
        data_rdata_i = sl_data;
      end else begin
        sl_cnt--;
      end
    end else if (stray_ok && !m_busy) begin
      data_data_ok = 1'b1;
    end
    @(negedge clk);
    iss = !m_busy && !m_done && d_en && !d_flush;
    e_req = 1'b0; e_wr = 1'b0; e_size = 2'd0; e_addr = 32'd0; e_wstrb = 4'd0; e_wdata = 32'd0;
    if (iss) begin
      e_req = 1'b1; e_wr = |d_wen; e_size = size_of(d_wen, d_rlen);
      e_addr = d_addr; e_wstrb = d_wen; e_wdata = d_wdata;
    end else if (m_busy && !m_acc) begin
      e_req = 1'b1; e_wr = m_wr; e_size = m_size;
      e_addr = m_addr; e_wstrb = m_wstrb; e_wdata = m_wdata;
    end
    e_stall = iss || m_busy;
    obs_req = data_req; obs_wr = data_wr; obs_size = data_size; obs_addr = data_addr;
    obs_wstrb = data_wstrb; obs_stall = mem_stall; obs_rdata = data_sram_rdata;
    if (obs_req) req_pulses++;
    check("req", 32'(data_req), 32'(e_req));
    check("wr", 32'(data_wr), 32'(e_wr));
    check("size", 32'(data_size), 32'(e_size));
    check("addr", data_addr, e_addr);
    check("wstrb", 32'(data_wstrb), 32'(e_wstrb));
    check("wdata", data_wdata, e_wdata);
    check("stall", 32'(mem_stall), 32'(e_stall));
    check("rdata", data_sram_rdata, m_rdata);
    data_addr_ok = obs_req && (sl_age >= alat);
    @(posedge clk);
    #1;
    if (iss) begin
      m_busy = 1'b1; m_acc = data_addr_ok; m_kill = 1'b0; m_wr = |d_wen;
      m_size = size_of(d_wen, d_rlen); m_addr = d_addr; m_wstrb = d_wen; m_wdata = d_wdata;
    end else if (m_busy && !m_acc) begin
      if (d_flush) m_kill = 1'b1;
      if (data_addr_ok) m_acc = 1'b1;
    end else if (m_busy) begin
      if (data_data_ok) begin
        if (!m_kill && !d_flush) begin
          m_done = 1'b1;
          if (!m_wr) m_rdata = data_rdata_i;
        end
        m_busy = 1'b0;
        m_kill = 1'b0;
      end else if (d_flush) begin
        m_kill = 1'b1;
      end
    end else if (m_done) begin
      if (d_adv || d_flush) m_done = 1'b0;
    end
    if (data_data_ok && sl_pend) sl_pend = 1'b0;
    if (obs_req) begin
      if (data_addr_ok) begin
        sl_pend = 1'b1; sl_cnt = dlat; sl_data = rsp_data; sl_age = 0;
      end else begin
        sl_age++;
      end
    end else begin
      sl_age = 0;
    end
    data_addr_ok = 1'b0;
  endtask

  // Retire whatever is in flight, with a bounded cycle budget.
  task automatic drain();
    int n;
    d_en = 1'b0; d_flush = 1'b0; d_adv = 1'b1; alat = 0; dlat = 0; stray_ok = 1'b0;
    n = 0;
    while ((m_busy || m_done) && n < 20) begin
      step();
      n++;
    end
    check("drain_bound", 32'(n < 20), 32'd1);
    d_adv = 1'b0;
  endtask

  task automatic set_load(input logic [31:0] a);
    d_en = 1'b1; d_wen = 4'b0000; d_rlen = 2'd2; d_addr = a; d_wdata = 32'd0;
    d_flush = 1'b0; d_adv = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int p0;
    rst = 1'b1;
    data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata_i = 32'd0;
    stray_ok = 1'b0; alat = 0; dlat = 0; rsp_data = 32'd0;
    set_load(32'h0000_1000);
    data_sram_en = 1'b1; data_sram_rlen = 2'd2; data_sram_wen = 4'd0;
    data_sram_addr = 32'h1000; data_sram_wdata = 32'd0; flush = 1'b0; pipe_advance = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_req", 32'(data_req), 32'd0);
    check("rst_stall", 32'(mem_stall), 32'd0);
    check("rst_rdata", data_sram_rdata, 32'd0);
    rst = 1'b0;

    // LW 0x1000, addr_ok at issue, data_ok next cycle, then hold in DONE
    set_load(32'h0000_1000); alat = 0; dlat = 0; rsp_data = 32'hDEAD_BEEF;
    p0 = req_pulses;
    step();
    check("lw_req", 32'(obs_req), 32'd1);
    check("lw_wr", 32'(obs_wr), 32'd0);
    check("lw_size", 32'(obs_size), 32'd2);
    check("lw_stall0", 32'(obs_stall), 32'd1);
    step();
    check("lw_stall1", 32'(obs_stall), 32'd1);
    for (int i = 0; i < 3; i++) begin
      step();
      check("lw_hold_stall", 32'(obs_stall), 32'd0);
      check("lw_hold_rdata", obs_rdata, 32'hDEAD_BEEF);
    end
    d_adv = 1'b1;
    step();
    check("lw_one_pulse", 32'(req_pulses - p0), 32'd1);
    d_adv = 1'b0; d_addr = 32'h0000_1004; rsp_data = 32'hCAFE_F00D;
    step();
    check("lw_reissue_req", 32'(obs_req), 32'd1);
    check("lw_reissue_addr", obs_addr, 32'h0000_1004);
    drain();
    check("lw2_rdata", data_sram_rdata, 32'hCAFE_F00D);

    // SH 0x2002 wen 1100, addr_ok after 3 waiting cycles, data_ok 2 later
    d_en = 1'b1; d_wen = 4'b1100; d_rlen = 2'd0; d_addr = 32'h0000_2002;
    d_wdata = 32'hBEEF_BEEF; alat = 3; dlat = 1; rsp_data = 32'h1111_1111;
    for (int i = 0; i < 6; i++) begin
      step();
      check("sh_stall", 32'(obs_stall), 32'd1);
      if (i < 4) begin
        check("sh_req", 32'(obs_req), 32'd1);
        check("sh_size", 32'(obs_size), 32'd1);
        check("sh_wstrb", 32'(obs_wstrb), 32'hC);
        check("sh_addr", obs_addr, 32'h0000_2002);
      end else begin
        check("sh_req_low", 32'(obs_req), 32'd0);
      end
    end
    step();
    check("sh_done_stall", 32'(obs_stall), 32'd0);
    check("sh_rdata_kept", obs_rdata, 32'hCAFE_F00D);
    drain();

    // flush in WAIT_DATA, response arrives 2 cycles later and is dropped
    set_load(32'h0000_1010); alat = 0; dlat = 2; rsp_data = 32'h1234_5678;
    step();
    d_flush = 1'b1;
    step();
    d_flush = 1'b0;
    step();
    step();
    d_en = 1'b0;
    step();
    check("fwd_stall", 32'(obs_stall), 32'd0);
    check("fwd_rdata", obs_rdata, 32'hCAFE_F00D);
    set_load(32'h0000_1014); alat = 0; dlat = 0; rsp_data = 32'h0BAD_CAFE;
    step();
    check("fwd_next_req", 32'(obs_req), 32'd1);
    step();
    step();
    check("fwd_next_rdata", obs_rdata, 32'h0BAD_CAFE);
    drain();

    // flush in WAIT_ADDR, request stays up until addr_ok, response dropped
    set_load(32'h0000_1018); alat = 3; dlat = 0; rsp_data = 32'h5555_5555;
    step();
    d_flush = 1'b1;
    step();
    check("fwa_req_flush", 32'(obs_req), 32'd1);
    d_flush = 1'b0;
    step();
    step();
    check("fwa_req_held", 32'(obs_req), 32'd1);
    step();
    d_en = 1'b0;
    step();
    check("fwa_stall", 32'(obs_stall), 32'd0);
    check("fwa_rdata", obs_rdata, 32'h0BAD_CAFE);
    drain();

    // reset while waiting for data, then a byte store
    set_load(32'h0000_1020); alat = 0; dlat = 5; rsp_data = 32'h7777_7777;
    step();
    step();
    rst = 1'b1;
    #2;
    check("arst_req", 32'(data_req), 32'd0);
    check("arst_stall", 32'(mem_stall), 32'd0);
    check("arst_rdata", data_sram_rdata, 32'd0);
    check("arst_fields", {data_addr[27:0], data_wstrb}, 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    d_en = 1'b1; d_wen = 4'b1000; d_rlen = 2'd0; d_addr = 32'h0000_3003;
    d_wdata = 32'hABAB_ABAB; alat = 0; dlat = 0;
    step();
    check("sb_req", 32'(obs_req), 32'd1);
    check("sb_size", 32'(obs_size), 32'd0);
    check("sb_wstrb", 32'(obs_wstrb), 32'h8);
    drain();

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      d_en = 1'($urandom_range(0, 1));
      d_rlen = 2'($urandom_range(0, 2));
      d_wen = ($urandom_range(0, 1) == 0) ? 4'b0000 : wen_tab[$urandom_range(0, 7)];
      d_addr = $urandom;
      d_wdata = $urandom;
      d_flush = ($urandom_range(0, 7) == 0);
      d_adv = ($urandom_range(0, 2) == 0);
      alat = $urandom_range(0, 3);
      dlat = $urandom_range(0, 3);
      rsp_data = $urandom;
      stray_ok = ($urandom_range(0, 15) == 0);
      step();
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
